// File: rtl/multi_echo_processor.sv
// -----------------------------------------------------------------------------
// multi_echo_processor
//
// Purpose:
//   Audio echo processor. It takes offset-binary ADC samples, applies a volume
//   gain, optionally subtracts an attenuated copy of the output from
//   delay_len samples earlier (a recursive "multi-echo"), and produces
//   offset-binary DAC samples. One sample is processed per four-cycle FSM
//   pass: IDLE -> FETCH -> MIX -> STORE.
//
// Ports:
//   sysclk        in   system clock, all flops on posedge
//   reset         in   asynchronous active-high reset
//   data_in       in   [DATA_W]  offset-binary ADC sample
//   data_valid    in   ADC sample-ready level (asynchronous to sysclk)
//   volume        in   [4]  unsigned gain, 8 = unity
//   delay_len     in   [ADDR_W]  echo delay in samples
//   echo_en       in   1 = add the echo feedback path
//   data_out      out  [DATA_W]  offset-binary DAC sample, registered
//   sample_strobe out  one-cycle pulse while data_out holds a new sample
//   overrun       out  sticky: a sample pulse was dropped
//
// Configuration macro:
//   MULTI_ECHO_SATURATE_EN  defined   -> gain and mix results clamp to the
//                                        signed DATA_W range
//                           undefined -> results wrap (two's complement)
// -----------------------------------------------------------------------------
module multi_echo_processor #(
    parameter int                DATA_W     = 10,
    parameter int                ADDR_W     = 11,
    parameter int                ATT_SHIFT  = 1,
    parameter logic [DATA_W-1:0] ADC_OFFSET = 10'h181,
    parameter logic [DATA_W-1:0] DAC_OFFSET = 10'h200
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    input  logic [3:0]        volume,
    input  logic [ADDR_W-1:0] delay_len,
    input  logic              echo_en,
    output logic [DATA_W-1:0] data_out,
    output logic              sample_strobe,
    output logic              overrun
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_MIX   = 2'd2,
        ST_STORE = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] FILL_MAX = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

`ifdef MULTI_ECHO_SATURATE_EN
    localparam logic signed [DATA_W+3:0] SAT_MAX = {{5{1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W+3:0] SAT_MIN = {{5{1'b1}}, {(DATA_W-1){1'b0}}};
`endif

    // Reduce a wide signed intermediate to DATA_W bits (clamp or wrap).
    function automatic logic [DATA_W-1:0] fit_w(input logic signed [DATA_W+3:0] v);
        logic [DATA_W-1:0] r;
`ifdef MULTI_ECHO_SATURATE_EN
        if (v > SAT_MAX) begin
            r = SAT_MAX[DATA_W-1:0];
        end else if (v < SAT_MIN) begin
            r = SAT_MIN[DATA_W-1:0];
        end else begin
            r = v[DATA_W-1:0];
        end
`else
        r = v[DATA_W-1:0];
`endif
        return r;
    endfunction

    state_t              state_q,    state_d;
    logic                sync1_q,    sync1_d;
    logic                sync2_q,    sync2_d;
    logic                sync3_q,    sync3_d;
    logic [DATA_W-1:0]   x_q,        x_d;
    logic [3:0]          vol_q,      vol_d;
    logic [ADDR_W-1:0]   dly_q,      dly_d;
    logic                echo_q,     echo_d;
    logic [DATA_W-1:0]   y_q,        y_d;
    logic [ADDR_W-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [ADDR_W-1:0]   fill_q,     fill_d;
    logic [ADDR_W-1:0]   prev_dly_q, prev_dly_d;
    logic                prev_vld_q, prev_vld_d;
    logic [DATA_W-1:0]   dout_q,     dout_d;
    logic                strobe_q,   strobe_d;
    logic                ovr_q,      ovr_d;

    logic [DATA_W-1:0]   mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0]   rd_data_q;
    logic [ADDR_W-1:0]   rd_addr_s;
    logic                we_s;
    logic                pulse_s;

    logic signed [DATA_W+3:0] prod_s;
    logic signed [DATA_W+3:0] zfull_s;
    logic signed [DATA_W-1:0] z_s;
    logic                     echo_on_s;
    logic signed [DATA_W-1:0] e_s;
    logic signed [DATA_W+3:0] ydiff_s;
    logic signed [DATA_W-1:0] y_s;

    // Mix datapath: gain, echo term and difference, all from latched values.
    always_comb begin
        prod_s    = $signed({{4{x_q[DATA_W-1]}}, x_q}) * $signed({{DATA_W{1'b0}}, vol_q});
        zfull_s   = prod_s >>> 2'd3;
        z_s       = fit_w(zfull_s);
        // The echo is only valid once the RAM holds delay_len fresh samples.
        echo_on_s = echo_q && (dly_q != ADDR_ZERO) && (fill_q >= dly_q);
        if (echo_on_s) begin
            e_s = $signed(rd_data_q) >>> ATT_SHIFT;
        end else begin
            e_s = {DATA_W{1'b0}};
        end
        ydiff_s   = {{4{z_s[DATA_W-1]}}, z_s} - {{4{e_s[DATA_W-1]}}, e_s};
        y_s       = fit_w(ydiff_s);
    end

    // Next-state logic: synchroniser, FSM sequencing and per-state updates.
    always_comb begin
        sync1_d    = data_valid;
        sync2_d    = sync1_q;
        sync3_d    = sync2_q;
        pulse_s    = sync2_q & ~sync3_q;
        state_d    = state_q;
        x_d        = x_q;
        vol_d      = vol_q;
        dly_d      = dly_q;
        echo_d     = echo_q;
        y_d        = y_q;
        wr_ptr_d   = wr_ptr_q;
        fill_d     = fill_q;
        prev_dly_d = prev_dly_q;
        prev_vld_d = prev_vld_q;
        dout_d     = dout_q;
        strobe_d   = 1'b0;
        we_s       = 1'b0;
        rd_addr_s  = wr_ptr_q - dly_q;
        // Any pulse outside IDLE is lost; remember that until reset.
        ovr_d      = ovr_q | (pulse_s & (state_q != ST_IDLE));

        case (state_q)
            ST_IDLE: begin
                if (pulse_s) begin
                    state_d = ST_FETCH;
                    x_d     = data_in - ADC_OFFSET;
                    vol_d   = volume;
                    dly_d   = delay_len;
                    echo_d  = echo_en;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_d = ST_MIX;
            end
            ST_MIX: begin
                // Output is loaded here so it and the strobe appear in STORE.
                state_d  = ST_STORE;
                y_d      = y_s;
                dout_d   = y_s + DAC_OFFSET;
                strobe_d = 1'b1;
            end
            ST_STORE: begin
                state_d    = ST_IDLE;
                we_s       = 1'b1;
                wr_ptr_d   = wr_ptr_q + ADDR_ONE;
                // A new delay makes the older history invalid for the echo.
                if (prev_vld_q && (prev_dly_q != dly_q)) begin
                    fill_d = ADDR_ZERO;
                end else if (fill_q != FILL_MAX) begin
                    fill_d = fill_q + ADDR_ONE;
                end else begin
                    fill_d = fill_q;
                end
                prev_dly_d = dly_q;
                prev_vld_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and output registers with asynchronous reset.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            sync3_q    <= 1'b0;
            x_q        <= {DATA_W{1'b0}};
            vol_q      <= 4'd0;
            dly_q      <= ADDR_ZERO;
            echo_q     <= 1'b0;
            y_q        <= {DATA_W{1'b0}};
            wr_ptr_q   <= ADDR_ZERO;
            fill_q     <= ADDR_ZERO;
            prev_dly_q <= ADDR_ZERO;
            prev_vld_q <= 1'b0;
            dout_q     <= DAC_OFFSET;
            strobe_q   <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            sync3_q    <= sync3_d;
            x_q        <= x_d;
            vol_q      <= vol_d;
            dly_q      <= dly_d;
            echo_q     <= echo_d;
            y_q        <= y_d;
            wr_ptr_q   <= wr_ptr_d;
            fill_q     <= fill_d;
            prev_dly_q <= prev_dly_d;
            prev_vld_q <= prev_vld_d;
            dout_q     <= dout_d;
            strobe_q   <= strobe_d;
            ovr_q      <= ovr_d;
        end
    end

    // Echo RAM: write in STORE, synchronous read of the delayed sample in FETCH.
    always_ff @(posedge sysclk) begin
        if (we_s) begin
            mem[wr_ptr_q] <= y_q;
        end
        if (state_q == ST_FETCH) begin
            rd_data_q <= mem[rd_addr_s];
        end
    end

    assign data_out      = dout_q;
    assign sample_strobe = strobe_q;
    assign overrun       = ovr_q;

endmodule
